// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
//  Module : viterbi_pkg
//  Brief  : Shared code constants, state type and branch-symbol helpers for
//           the K=3, rate-1/2 (7,5 octal) hard-decision Viterbi decoder.
//  Rev    : 1.0  initial release
// ============================================================================
package viterbi_pkg;

    localparam int         K      = 3;
    localparam int         NSTATE = 4;
    localparam logic [2:0] G0     = 3'b111;
    localparam logic [2:0] G1     = 3'b101;

    // State {s1,s0}; s1 is the most recent past input bit
    typedef logic [1:0] state_t;

    // Code symbol {g0,g1} emitted when input u is applied in state s
    function automatic logic [1:0] branch_sym(state_t s, logic u);
        logic [2:0] w_reg;
        w_reg = {u, s};
        return {^(w_reg & G0), ^(w_reg & G1)};
    endfunction

    // Hamming distance between two 2-bit symbols (0..2)
    function automatic logic [1:0] hamming2(logic [1:0] a, logic [1:0] b);
        logic [1:0] w_x;
        w_x = a ^ b;
        return {w_x[1] & w_x[0], w_x[1] ^ w_x[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/viterbi_acs.sv
`default_nettype none
// ============================================================================
//  Module : viterbi_acs
//  Brief  : Add-compare-select for one trellis state. Adds each branch metric
//           to its predecessor metric with saturation and keeps the smaller;
//           ties go to the predecessor with s0 = 0.
//  Rev    : 1.0  initial release
// ============================================================================
module viterbi_acs #(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] i_pm0,   // metric of predecessor {p,0}
    input  logic [PM_W-1:0] i_pm1,   // metric of predecessor {p,1}
    input  logic [1:0]      i_bm0,   // branch metric from {p,0}
    input  logic [1:0]      i_bm1,   // branch metric from {p,1}
    output logic [PM_W-1:0] o_pm,    // surviving (saturated) metric
    output logic            o_dec    // 1 = predecessor {p,1} won
);

    logic [PM_W:0]   w_sum0;
    logic [PM_W:0]   w_sum1;
    logic [PM_W-1:0] w_c0;
    logic [PM_W-1:0] w_c1;

    // Saturating add of both candidates, then strict-less-than select
    always_comb begin
        w_sum0 = {1'b0, i_pm0} + {{(PM_W-1){1'b0}}, i_bm0};
        w_sum1 = {1'b0, i_pm1} + {{(PM_W-1){1'b0}}, i_bm1};
        w_c0   = w_sum0[PM_W] ? {PM_W{1'b1}} : w_sum0[PM_W-1:0];
        w_c1   = w_sum1[PM_W] ? {PM_W{1'b1}} : w_sum1[PM_W-1:0];
        o_dec  = (w_c1 < w_c0);
        o_pm   = o_dec ? w_c1 : w_c0;
    end

endmodule
`default_nettype wire

// File: rtl/viterbi_decoder.sv
`default_nettype none
// ============================================================================
//  Module : viterbi_decoder
//  Brief  : Hard-decision Viterbi decoder, K=3 rate-1/2 (7,5) code, 4-state
//           ACS with register-exchange survivors. One decoded bit per accepted
//           symbol after a fixed TB_DEPTH-symbol decision delay.
//           Optional macro VITERBI_ERRCNT_EN adds the err_cnt_o counter of
//           corrected channel bits.
//  Rev    : 1.0  initial release
// ============================================================================
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = 15,    // survivor length / decision delay, 5..32
    parameter int PM_W     = 6      // path-metric width
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active low
    input  logic        enable_i,
    input  logic        valid_i,
    input  logic [1:0]  d_in,
    output logic        valid_o,
    output logic        d_out
`ifdef VITERBI_ERRCNT_EN
    ,
    output logic [15:0] err_cnt_o
`endif
);

    localparam int CNT_W = $clog2(TB_DEPTH + 1);

    logic [PM_W-1:0]     r_pm       [NSTATE];
    logic [TB_DEPTH-1:0] r_surv     [NSTATE];
    logic [CNT_W-1:0]    r_cnt;
    logic                r_valid;
    logic                r_dout;

    logic [PM_W-1:0]     w_pm_new   [NSTATE];
    logic [PM_W-1:0]     w_pm_norm  [NSTATE];
    logic [TB_DEPTH-1:0] w_surv_new [NSTATE];
    logic                w_dec      [NSTATE];
    logic [PM_W-1:0]     w_min;
    state_t              w_best;
    logic                w_acc;
    logic                w_full;

    assign w_acc   = enable_i & valid_i;
    assign w_full  = (r_cnt >= CNT_W'(TB_DEPTH - 1));
    assign valid_o = r_valid;
    assign d_out   = r_dout;

    // One ACS per next state {u,p}; predecessors are {p,0} and {p,1}
    for (genvar gi = 0; gi < NSTATE; gi++) begin : g_acs
        localparam int     C_P     = gi % 2;
        localparam int     C_U     = gi / 2;
        localparam state_t C_PRED0 = state_t'(2 * C_P);
        localparam state_t C_PRED1 = state_t'(2 * C_P + 1);
        localparam logic   C_UBIT  = (C_U != 0);

        logic [1:0] w_bm0;
        logic [1:0] w_bm1;

        assign w_bm0 = hamming2(d_in, branch_sym(C_PRED0, C_UBIT));
        assign w_bm1 = hamming2(d_in, branch_sym(C_PRED1, C_UBIT));

        viterbi_acs #(
            .PM_W (PM_W)
        ) u_acs (
            .i_pm0 (r_pm[C_PRED0]),
            .i_pm1 (r_pm[C_PRED1]),
            .i_bm0 (w_bm0),
            .i_bm1 (w_bm1),
            .o_pm  (w_pm_new[gi]),
            .o_dec (w_dec[gi])
        );

        // Survivor of the winning predecessor, shifted with this state's input bit
        assign w_surv_new[gi] = w_dec[gi]
                              ? {r_surv[C_PRED1][TB_DEPTH-2:0], C_UBIT}
                              : {r_surv[C_PRED0][TB_DEPTH-2:0], C_UBIT};
    end

    // Minimum new metric and the lowest-index state holding it
    always_comb begin
        w_min  = w_pm_new[0];
        w_best = state_t'(0);
        for (int i = 1; i < NSTATE; i++) begin
            if (w_pm_new[i] < w_min) begin
                w_min  = w_pm_new[i];
                w_best = state_t'(i);
            end
        end
        for (int i = 0; i < NSTATE; i++) begin
            w_pm_norm[i] = w_pm_new[i] - w_min;
        end
    end

    // Path metrics and survivors advance only on an accepted symbol
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSTATE; i++) begin
                r_pm[i]   <= (i == 0) ? '0 : PM_W'(4);
                r_surv[i] <= '0;
            end
        end else if (w_acc) begin
            for (int i = 0; i < NSTATE; i++) begin
                r_pm[i]   <= w_pm_norm[i];
                r_surv[i] <= w_surv_new[i];
            end
        end
    end

    // Fill counter and registered output bit / valid strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_dout  <= 1'b0;
        end else begin
            r_valid <= w_acc & w_full;
            if (w_acc) begin
                if (r_cnt != CNT_W'(TB_DEPTH)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_dout <= w_surv_new[w_best][TB_DEPTH-1];
            end
        end
    end

`ifdef VITERBI_ERRCNT_EN
    logic [15:0] r_err;
    logic [16:0] w_err_sum;

    assign w_err_sum = {1'b0, r_err} + 17'(w_min);
    assign err_cnt_o = r_err;

    // Accumulate errors absorbed by the best path, saturating at 16 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= '0;
        end else if (w_acc) begin
            r_err <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_viterbi_decoder.sv
`default_nettype none
// ============================================================================
//  Module : tb_viterbi_decoder
//  Brief  : Scoreboard bench for viterbi_decoder. Source bits are queued as
//           symbols are driven; a monitor pops one bit per valid_o pulse.
//  Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_viterbi_decoder;

    localparam int TB_DEPTH = 15;
    localparam int PM_W     = 6;
    localparam int NCLEAN   = 30;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       enable_i = 1'b0;
    logic       valid_i  = 1'b0;
    logic [1:0] d_in     = 2'b00;
    logic       valid_o;
    logic       d_out;
`ifdef VITERBI_ERRCNT_EN
    logic [15:0] err_cnt_o;
`endif

    int   checks   = 0;
    int   failures = 0;
    bit   exp_q[$];
    int   acc_cnt  = 0;
    bit   exp_valid = 1'b0;
    bit   mon_exp;
    logic [1:0] enc_s = 2'b00;

    // Hand-encoded clean stream: bits 1,0,0,0,1,0,0,1,1,0 followed by zeros
    bit         clean_bits [NCLEAN] = '{1,0,0,0,1,0,0,1,1,0,
                                        0,0,0,0,0,0,0,0,0,0,
                                        0,0,0,0,0,0,0,0,0,0};
    logic [1:0] clean_syms [NCLEAN] = '{2'b11,2'b10,2'b11,2'b00,2'b11,
                                        2'b10,2'b11,2'b11,2'b01,2'b01,
                                        2'b11,2'b00,2'b00,2'b00,2'b00,
                                        2'b00,2'b00,2'b00,2'b00,2'b00,
                                        2'b00,2'b00,2'b00,2'b00,2'b00,
                                        2'b00,2'b00,2'b00,2'b00,2'b00};

    always #5 clk = ~clk;

    viterbi_decoder #(
        .TB_DEPTH (TB_DEPTH),
        .PM_W     (PM_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable_i (enable_i),
        .valid_i  (valid_i),
        .d_in     (d_in),
        .valid_o  (valid_o),
        .d_out    (d_out)
`ifdef VITERBI_ERRCNT_EN
        ,
        .err_cnt_o(err_cnt_o)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected valid_o timing: one pulse after each accept once TB_DEPTH reached
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_cnt   = 0;
            exp_valid = 1'b0;
        end else if (enable_i && valid_i) begin
            if (acc_cnt < TB_DEPTH) acc_cnt++;
            exp_valid = (acc_cnt >= TB_DEPTH);
        end else begin
            exp_valid = 1'b0;
        end
    end

    // Monitor: check valid_o every cycle, pop and compare d_out on each pulse
    always @(negedge clk) begin
        checks++;
        if (valid_o !== exp_valid) begin
            failures++;
            $display("FAIL valid_o: got %b expected %b at %0t", valid_o, exp_valid, $time);
        end
        if (valid_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard: valid_o with no expected bit at %0t", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (d_out !== mon_exp) begin
                    failures++;
                    $display("FAIL d_out: got %b expected %b at %0t", d_out, mon_exp, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drive one symbol for one accepting edge; queue the source bit it carries
    task automatic send(input logic [1:0] sym, input bit b);
        exp_q.push_back(b);
        enable_i = 1'b1;
        valid_i  = 1'b1;
        d_in     = sym;
        tick();
        valid_i  = 1'b0;
    endtask

    function automatic logic [1:0] encode(input bit u);
        logic [1:0] s;
        s     = {u ^ enc_s[1] ^ enc_s[0], u ^ enc_s[0]};
        enc_s = {u, enc_s[1]};
        return s;
    endfunction

    task automatic reset_dut();
        rst = 1'b0;
        tick();
        check("reset valid_o", int'(valid_o), 0);
        check("reset d_out", int'(d_out), 0);
`ifdef VITERBI_ERRCNT_EN
        check("reset err_cnt_o", int'(err_cnt_o), 0);
`endif
        exp_q.delete();
        enc_s = 2'b00;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic end_stream(input string name);
        valid_i = 1'b0;
        tick();
        tick();
        check(name, exp_q.size(), TB_DEPTH - 1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [1:0] sym;
        bit         b;
        bit         held;

        // 1: clean stream
        reset_dut();
        for (int i = 0; i < NCLEAN; i++) send(clean_syms[i], clean_bits[i]);
        end_stream("t1 leftover");
`ifdef VITERBI_ERRCNT_EN
        check("t1 err_cnt_o", int'(err_cnt_o), 0);
`endif

        // 2: symbol 3 corrupted 11 -> 01
        reset_dut();
        for (int i = 0; i < NCLEAN; i++)
            send((i == 2) ? 2'b01 : clean_syms[i], clean_bits[i]);
        end_stream("t2 leftover");
`ifdef VITERBI_ERRCNT_EN
        check("t2 err_cnt_o", int'(err_cnt_o), 1);
`endif

        // 3: random idle gaps between symbols
        reset_dut();
        for (int i = 0; i < NCLEAN; i++) begin
            send(clean_syms[i], clean_bits[i]);
            repeat ($urandom_range(1, 3)) tick();
        end
        end_stream("t3 leftover");

        // 4: enable low for 5 cycles with valid_i high, after symbol 20
        reset_dut();
        for (int i = 0; i < NCLEAN; i++) begin
            if (i == 20) begin
                held     = d_out;
                enable_i = 1'b0;
                valid_i  = 1'b1;
                d_in     = clean_syms[i];
                for (int k = 0; k < 5; k++) begin
                    tick();
                    check("t4 d_out hold", int'(d_out), int'(held));
                    check("t4 valid_o low", int'(valid_o), 0);
                end
                valid_i  = 1'b0;
                enable_i = 1'b1;
            end
            send(clean_syms[i], clean_bits[i]);
        end
        end_stream("t4 leftover");

        // 5: reset after symbol 7, then restart the clean stream
        reset_dut();
        for (int i = 0; i < 7; i++) send(clean_syms[i], clean_bits[i]);
        rst = 1'b0;
        #1;
        check("t5 valid_o on reset", int'(valid_o), 0);
        check("t5 d_out on reset", int'(d_out), 0);
        exp_q.delete();
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < NCLEAN; i++) send(clean_syms[i], clean_bits[i]);
        end_stream("t5 leftover");

        // 6: 2000 random bits, one bit error every 20 symbols, plus flush
        reset_dut();
        for (int i = 0; i < 2020; i++) begin
            b   = (i < 2000) ? bit'($urandom_range(0, 1)) : 1'b0;
            sym = encode(b);
            if ((i % 20) == 10 && i < 2000)
                sym = sym ^ (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10);
            send(sym, b);
        end
        end_stream("t6 leftover");
`ifdef VITERBI_ERRCNT_EN
        check("t6 err_cnt_o", int'(err_cnt_o), 100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
